// File: rtl/freq_gate_counter.sv
`default_nettype none
// freq_gate_counter: reciprocal gate counter. It opens and closes its gate on edges of sig_in
// and publishes the reference-cycle count (fs) and the signal-period count (fx) for each gate.
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES    = 200_000_000,
  parameter int unsigned GAP_CYCLES     = 20_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 400_000_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        meas_en,
  input  logic        sig_in,
  output logic [31:0] fs_cnt,
  output logic [31:0] fx_cnt,
  output logic        no_signal,
  output logic        cnt_valid
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPEN = 2'd1,
    COUNT     = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam logic [31:0] GATE_LEN = 32'(GATE_CYCLES);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LEN   = 32'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic        s0;
  logic        s1;
  logic        s2;
  logic        sig_rise;
  logic [31:0] fs_acc;
  logic [31:0] fx_acc;
  logic [31:0] to_cnt;
  logic [31:0] gap_cnt;
  logic [31:0] fs_next;
  logic [31:0] fx_next;
  logic [31:0] to_next;
  logic        open_gate;
  logic        pub_ok;
  logic        pub_to;
  logic        to_clear;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= sig_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign sig_rise = s1 & ~s2;
  assign fs_next  = fs_acc + 32'd1;
  assign fx_next  = fx_acc + 32'd1;
  assign to_next  = to_cnt + 32'd1;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Priority inside a gate: enable drop aborts, then an edge (which also defeats a
  // coincident timeout terminal count), then the timeout.
  always_comb begin
    state_next = state;
    open_gate  = 1'b0;
    pub_ok     = 1'b0;
    pub_to     = 1'b0;
    to_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (meas_en) begin
          state_next = WAIT_OPEN;
          to_clear   = 1'b1;
        end
      end
      WAIT_OPEN: begin
        if (!meas_en) begin
          state_next = IDLE;
        end else if (sig_rise) begin
          open_gate  = 1'b1;
          state_next = COUNT;
        end else if (to_next == TO_LEN) begin
          pub_to     = 1'b1;
          state_next = GAP;
        end
      end
      COUNT: begin
        if (!meas_en) begin
          state_next = IDLE;
        end else if (sig_rise) begin
          if (fs_next >= GATE_LEN) begin
            pub_ok     = 1'b1;
            state_next = GAP;
          end
        end else if (to_next == TO_LEN) begin
          pub_to     = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_acc    <= 32'd0;
      fx_acc    <= 32'd0;
      to_cnt    <= 32'd0;
      gap_cnt   <= 32'd0;
      fs_cnt    <= 32'd0;
      fx_cnt    <= 32'd0;
      no_signal <= 1'b0;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= pub_ok | pub_to;

      if (pub_ok) begin
        fs_cnt    <= fs_next;
        fx_cnt    <= fx_next;
        no_signal <= 1'b0;
      end else if (pub_to) begin
        fs_cnt    <= 32'd0;
        fx_cnt    <= 32'd0;
        no_signal <= 1'b1;
      end

      if (to_clear || sig_rise) begin
        to_cnt <= 32'd0;
      end else if ((state == WAIT_OPEN) || (state == COUNT)) begin
        to_cnt <= to_next;
      end

      // The opening edge only zeroes the accumulators; counting starts next cycle.
      if (open_gate) begin
        fs_acc <= 32'd0;
        fx_acc <= 32'd0;
      end else if (state == COUNT) begin
        fs_acc <= fs_next;
        if (sig_rise) begin
          fx_acc <= fx_next;
        end
      end

      if (state == GAP) begin
        gap_cnt <= gap_cnt + 32'd1;
      end else begin
        gap_cnt <= 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_counter.sv
`default_nettype none
// tb_freq_gate_counter: directed and random stimulus against a timestamp-based reference model.
module tb_freq_gate_counter;

  localparam int GATE = 100;
  localparam int GAP  = 8;
  localparam int TMO  = 50;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_GATE  = 2;
  localparam int M_REST  = 3;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        meas_en;
  logic        sig_in;
  logic [31:0] fs_cnt;
  logic [31:0] fx_cnt;
  logic        no_signal;
  logic        cnt_valid;

  freq_gate_counter #(
    .GATE_CYCLES   (GATE),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .meas_en  (meas_en),
    .sig_in   (sig_in),
    .fs_cnt   (fs_cnt),
    .fx_cnt   (fx_cnt),
    .no_signal(no_signal),
    .cnt_valid(cnt_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int tick_no = 0;

  // Reference model: timestamps in clock-edge units.
  int  k = 0;
  int  mode = M_IDLE;
  int  t_open = 0;
  int  t_ref = 0;
  int  t_rest_end = 0;
  int  edges = 0;
  bit  p0 = 1'b0;
  bit  p1 = 1'b0;
  bit  p2 = 1'b0;
  logic [31:0] e_fs = 32'd0;
  logic [31:0] e_fx = 32'd0;
  bit  e_ns = 1'b0;
  bit  e_valid = 1'b0;

  logic [31:0] q_fs[$];
  logic [31:0] q_fx[$];
  bit          q_ns[$];
  int          q_tick[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", tag, got, exp, tick_no);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE;
    p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
    e_fs = 32'd0; e_fx = 32'd0; e_ns = 1'b0; e_valid = 1'b0;
  endtask

  task automatic publish(input int fs, input int fx, input bit ns);
    e_fs = 32'(fs); e_fx = 32'(fx); e_ns = ns; e_valid = 1'b1;
    mode = M_REST;
    t_rest_end = k + GAP;
  endtask

  // A synchronized rise acts two edges after the level is first sampled high.
  task automatic model_step(input bit en, input bit s);
    bit rise;
    rise = p1 & ~p2;
    p2 = p1; p1 = p0; p0 = s;
    k++;
    e_valid = 1'b0;
    case (mode)
      M_IDLE: if (en) begin mode = M_ARMED; t_ref = k; end
      M_ARMED, M_GATE: begin
        if (!en) begin
          mode = M_IDLE;
        end else if (rise) begin
          t_ref = k;
          if (mode == M_ARMED) begin
            mode = M_GATE; t_open = k; edges = 0;
          end else begin
            edges++;
            if (k - t_open >= GATE) publish(k - t_open, edges, 1'b0);
          end
        end else if (k - t_ref == TMO) begin
          publish(0, 0, 1'b1);
        end
      end
      default: if (k == t_rest_end) mode = M_IDLE;
    endcase
  endtask

  task automatic tick(input bit en, input bit s);
    meas_en = en;
    sig_in  = s;
    @(posedge sys_clk);
    model_step(en, s);
    @(negedge sys_clk);
    tick_no++;
    check_eq("fs_cnt", fs_cnt, e_fs);
    check_eq("fx_cnt", fx_cnt, e_fx);
    check_eq("no_signal", 32'(no_signal), 32'(e_ns));
    check_eq("cnt_valid", 32'(cnt_valid), 32'(e_valid));
    if (cnt_valid) begin
      q_fs.push_back(fs_cnt);
      q_fx.push_back(fx_cnt);
      q_ns.push_back(no_signal);
      q_tick.push_back(tick_no);
    end
  endtask

  task automatic clear_q();
    q_fs.delete(); q_fx.delete(); q_ns.delete(); q_tick.delete();
  endtask

  function automatic bit wave(input int period, input int i);
    if (period == 0) return 1'b0;
    if (period < 0) return 1'b1;
    return (i % period) < (period / 2);
  endfunction

  task automatic seg(input bit en, input int period, input int n, input int ph);
    for (int i = 0; i < n; i++) tick(en, wave(period, i + ph));
  endtask

  task automatic quiesce();
    seg(1'b0, 0, GAP + 6, 0);
  endtask

  task automatic do_reset(input int ncyc);
    meas_en = 1'b0;
    sig_in  = 1'b0;
    rst_n   = 1'b0;
    #1;
    model_reset();
    check_eq("rst_fs", fs_cnt, 32'd0);
    check_eq("rst_fx", fx_cnt, 32'd0);
    check_eq("rst_ns", 32'(no_signal), 32'd0);
    check_eq("rst_valid", 32'(cnt_valid), 32'd0);
    repeat (ncyc) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  task automatic run_measure(input int period, input int nres, input int maxc);
    clear_q();
    for (int i = 0; i < maxc && q_fs.size() < nres; i++) tick(1'b1, wave(period, i));
    check_eq("n_results", 32'(q_fs.size()), 32'(nres));
  endtask

  task automatic expect_result(input string tag, input int idx,
                               input int fs, input int fx, input bit ns);
    if (q_fs.size() > idx) begin
      check_eq({tag, "_fs"}, q_fs[idx], 32'(fs));
      check_eq({tag, "_fx"}, q_fx[idx], 32'(fx));
      check_eq({tag, "_ns"}, 32'(q_ns[idx]), 32'(ns));
    end
  endtask

  initial begin
    int t0;
    rst_n   = 1'b0;
    meas_en = 1'b0;
    sig_in  = 1'b0;
    repeat (3) @(negedge sys_clk);
    do_reset(2);

    // Period 10: two back-to-back results.
    run_measure(10, 2, 700);
    expect_result("p10_a", 0, 100, 10, 1'b0);
    expect_result("p10_b", 1, 100, 10, 1'b0);

    quiesce();
    run_measure(7, 1, 400);
    expect_result("p7", 0, 105, 15, 1'b0);

    quiesce();
    run_measure(30, 1, 500);
    expect_result("p30", 0, 120, 4, 1'b0);

    // Input held low: timeout 50 cycles after WAIT_OPEN entry.
    quiesce();
    clear_q();
    t0 = tick_no;
    seg(1'b1, 0, 70, 0);
    check_eq("lo_count", 32'(q_fs.size()), 32'd1);
    expect_result("lo", 0, 0, 0, 1'b1);
    if (q_tick.size() > 0) check_eq("lo_latency", 32'(q_tick[0] - t0), 32'd51);
    run_measure(10, 1, 400);
    expect_result("lo_recover", 0, 100, 10, 1'b0);

    // Edges then stuck high inside the gate.
    quiesce();
    clear_q();
    seg(1'b1, 10, 45, 0);
    seg(1'b1, -1, 80, 0);
    check_eq("hi_count", 32'(q_fs.size()), 32'd1);
    expect_result("hi", 0, 0, 0, 1'b1);

    // Enable dropped mid-gate: previous (timeout) result must persist.
    quiesce();
    clear_q();
    seg(1'b1, 10, 60, 0);
    seg(1'b0, 10, 20, 60);
    check_eq("abort_count", 32'(q_fs.size()), 32'd0);
    check_eq("abort_fs", fs_cnt, 32'd0);
    check_eq("abort_ns", 32'(no_signal), 32'd1);
    run_measure(10, 1, 400);
    expect_result("abort_recover", 0, 100, 10, 1'b0);

    // Reset mid-gate.
    quiesce();
    seg(1'b1, 10, 60, 0);
    do_reset(3);
    run_measure(10, 1, 400);
    expect_result("post_rst", 0, 100, 10, 1'b0);

    // Random segments; every cycle is checked against the model.
    for (int s = 0; s < 40; s++) begin
      int r;
      int per;
      bit en;
      r  = int'($urandom_range(0, 99));
      if (r < 5) do_reset(int'($urandom_range(1, 3)));
      en = ($urandom_range(0, 9) != 0);
      r  = int'($urandom_range(0, 99));
      if (r < 8) per = 0;
      else if (r < 13) per = -1;
      else per = int'($urandom_range(2, 40));
      seg(en, per, int'($urandom_range(20, 300)), int'($urandom_range(0, 39)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_gate_counter.md
# freq_gate_counter

Reciprocal (equal-precision) gate counter for the cymometer. It synchronizes the unknown input `sig_in` into `sys_clk` (200 MHz reference) and opens its measurement gate on a signal rising edge. It closes the gate on the first signal rising edge after at least `GATE_CYCLES` reference cycles, then publishes the reference count `fs_cnt` and the signal-edge count `fx_cnt` to the SPI readout stage, which sends both words plus the 200 MHz constant.

## Interface
Parameters:
- `GATE_CYCLES`, 200_000_000, minimum gate length in `sys_clk` cycles (1 s).
- `GAP_CYCLES`, 20_000_000, idle cycles between measurements (100 ms).
- `TIMEOUT_CYCLES`, 400_000_000, consecutive edge-free cycles that abort a measurement. `GATE_CYCLES + TIMEOUT_CYCLES` must be < 2^32.

Ports:
- `sys_clk`, in, 1, reference clock (200 MHz); the only clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `meas_en`, in, 1, run enable, level-sensitive.
- `sig_in`, in, 1, unknown signal; asynchronous to `sys_clk`.
- `fs_cnt`, out, 32, reference cycles in the last completed gate.
- `fx_cnt`, out, 32, signal periods in the last completed gate.
- `no_signal`, out, 1, set if the last result was a timeout.
- `cnt_valid`, out, 1, one-cycle pulse when new results are published.

## Operation
- Synchronizer: `sig_in` passes through a 3-flop chain s0→s1→s2. `sig_rise` = s1 & ~s2. At most one `sig_rise` is produced per input rising edge.
- FSM states: IDLE, WAIT_OPEN, COUNT, GAP.
  - IDLE: if `meas_en`, go to WAIT_OPEN and clear the timeout counter.
  - WAIT_OPEN: on `sig_rise`, clear `fs_acc` and `fx_acc`, clear the timeout counter, and go to COUNT. The opening edge is not counted.
  - COUNT, every cycle: fs_next = fs_acc+1. On `sig_rise`: fx_next = fx_acc+1.
  - COUNT, close: if `sig_rise` and fs_next >= `GATE_CYCLES`, publish fs_next and fx_next, then go to GAP. The closing edge and its cycle are counted, so fs = exact number of reference cycles spanning fx whole periods.
  - GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- Timeout: in WAIT_OPEN and COUNT, a counter increments every cycle without `sig_rise` and clears on `sig_rise`. When it reaches `TIMEOUT_CYCLES`, publish fs=0, fx=0, `no_signal`=1, and go to GAP.
- A normal publish clears `no_signal`.
- `meas_en` low in WAIT_OPEN or COUNT: abort and go to IDLE; accumulators are discarded; outputs and `no_signal` are unchanged; no `cnt_valid`.
- `meas_en` low in GAP: GAP completes, then the FSM stays in IDLE.
- Arithmetic: 32-bit unsigned throughout. Overflow is impossible given the parameter constraint; no saturation logic.
- Outputs hold their last published value indefinitely. The downstream stage samples them continuously.

## Timing
- Reset values: `fs_cnt`=0, `fx_cnt`=0, `no_signal`=0, `cnt_valid`=0, FSM=IDLE, synchronizer flops=0, all counters=0.
- Input latency: a `sig_in` rise captured by s0 at edge n gives `sig_rise` high in the cycle after edge n+1.
- Publish: `fs_cnt`, `fx_cnt` and `no_signal` update on the clock edge ending the close or timeout cycle. `cnt_valid` is high for exactly that following cycle, coincident with the new values. The FSM is in GAP during the pulse.
- IDLE→WAIT_OPEN takes one cycle. GAP lasts exactly `GAP_CYCLES` cycles.
- Reset asserted mid-measurement: immediate return to the reset values. No partial result is ever published.
- `sig_rise` in the same cycle as the timeout terminal count: the edge wins, the timeout counter clears, and no timeout occurs.

## Test plan
Bench parameters: GATE=100, GAP=8, TIMEOUT=50; `sig_in` driven as a clean square wave aligned to `sys_clk`.
- Period 10 cycles, `meas_en`=1 → `cnt_valid` pulse with fs=100, fx=10, `no_signal`=0; the next result arrives after GAP with the same values.
- Period 7 → fs=105, fx=15. Period 30 → fs=120, fx=4, which verifies that the gate extends to the next edge.
- `sig_in` held low → 50 cycles after WAIT_OPEN entry: fs=0, fx=0, `no_signal`=1, one `cnt_valid`. Then switch to period 10 → next result fs=100, fx=10 and `no_signal` cleared.
- Period 10 for 40 cycles of COUNT, then `sig_in` stuck high → timeout 50 cycles after the last edge with fs=0, fx=0, `no_signal`=1.
- `meas_en` dropped mid-COUNT → no `cnt_valid`, outputs keep the previous result, FSM in IDLE. Re-enable → a fresh full measurement.
- `rst_n` pulsed low mid-COUNT → all outputs 0 immediately. After release with period 10 → the first result is fs=100, fx=10.
